// File: rtl/calc_controller.sv
// calc_controller: hex-entry calculator core; builds operands digit by digit and
// applies add/subtract in one cycle or multiply through a sequential shift-add unit.
module calc_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             newhex_i,
    input  logic [3:0]       hexcode_i,
    input  logic             newop_i,
    input  logic [1:0]       opcode_i,
    input  logic             eq_i,
    output logic [WIDTH-1:0] display_o,
    output logic             busy_o,
    output logic             overflow_o
);
    typedef enum logic [2:0] {ENTRY_A, OP_WAIT, ENTRY_B, MUL_RUN, RESULT} state_e;
    localparam int CW = $clog2(WIDTH);

    state_e               state_q;
    logic [WIDTH-1:0]     a_q, b_q, display_q;
    logic [1:0]           op_q, pend_q;
    logic                 chain_q, busy_q, ovf_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH:0]       sum, diff, res;
    logic [WIDTH-1:0]     a_shift, b_shift, hex_ext;
    logic                 hex_only, op_only;

    assign hex_only = newhex_i && !newop_i && !eq_i;
    assign op_only  = newop_i && !eq_i;
    assign hex_ext  = {{(WIDTH-4){1'b0}}, hexcode_i};
    assign a_shift  = {a_q[WIDTH-5:0], hexcode_i};
    assign b_shift  = {b_q[WIDTH-5:0], hexcode_i};
    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    // Top bit of the widened difference is the borrow (A < B).
    assign diff     = {1'b0, a_q} - {1'b0, b_q};
    assign res      = (op_q == 2'b10) ? diff : sum;
    assign acc_d    = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ENTRY_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            pend_q    <= '0;
            chain_q   <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            display_q <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                ENTRY_A: begin
                    if (op_only) begin
                        op_q    <= opcode_i;
                        state_q <= OP_WAIT;
                    end else if (hex_only) begin
                        a_q       <= a_shift;
                        display_q <= a_shift;
                        ovf_q     <= 1'b0;
                    end
                end
                OP_WAIT: begin
                    if (op_only) begin
                        op_q <= opcode_i;
                    end else if (hex_only) begin
                        b_q       <= hex_ext;
                        display_q <= hex_ext;
                        state_q   <= ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (newop_i || eq_i) begin
                        chain_q <= !eq_i;
                        pend_q  <= opcode_i;
                        if (op_q == 2'b01) begin
                            state_q <= MUL_RUN;
                            busy_q  <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            a_q       <= res[WIDTH-1:0];
                            display_q <= res[WIDTH-1:0];
                            ovf_q     <= res[WIDTH];
                            state_q   <= eq_i ? RESULT : OP_WAIT;
                            if (!eq_i) op_q <= opcode_i;
                        end
                    end else if (newhex_i) begin
                        b_q       <= b_shift;
                        display_q <= b_shift;
                    end
                end
                MUL_RUN: begin
                    // The last iteration and the write-back share one cycle.
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        busy_q    <= 1'b0;
                        a_q       <= acc_d[WIDTH-1:0];
                        display_q <= acc_d[WIDTH-1:0];
                        ovf_q     <= |acc_d[2*WIDTH-1:WIDTH];
                        state_q   <= chain_q ? OP_WAIT : RESULT;
                        if (chain_q) op_q <= pend_q;
                    end
                end
                RESULT: begin
                    if (op_only) begin
                        op_q    <= opcode_i;
                        state_q <= OP_WAIT;
                    end else if (hex_only) begin
                        a_q       <= hex_ext;
                        b_q       <= '0;
                        ovf_q     <= 1'b0;
                        display_q <= hex_ext;
                        state_q   <= ENTRY_A;
                    end
                end
                default: state_q <= ENTRY_A;
            endcase
        end
    end

    assign display_o  = display_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: directed spec cases plus random key sequences checked against a keypress-level model.
module tb_calc_controller;
    localparam int W = 16;
    localparam int unsigned MASK = 32'h0000_FFFF;
    localparam int K_HEX = 0, K_OP = 1, K_EQ = 2;
    localparam int M_A = 0, M_OW = 1, M_B = 2, M_RES = 3;

    logic         clock_i, reset_n_i, newhex_i, newop_i, eq_i;
    logic [3:0]   hexcode_i;
    logic [1:0]   opcode_i;
    logic [W-1:0] display_o;
    logic         busy_o, overflow_o;

    int checks = 0;
    int errors = 0;

    int unsigned m_a, m_b, m_op, m_disp, m_ovf;
    int          m_mode;

    calc_controller #(.WIDTH(W)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .newhex_i(newhex_i), .hexcode_i(hexcode_i),
        .newop_i(newop_i), .opcode_i(opcode_i), .eq_i(eq_i), .display_o(display_o),
        .busy_o(busy_o), .overflow_o(overflow_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_ovf = 0; m_mode = M_A;
    endtask

    // Keypress-level calculator behaviour; returns whether a multiply was launched.
    task automatic model(input int kind, input int unsigned v, output bit mul);
        int unsigned r;
        mul = 0;
        case (m_mode)
            M_A: begin
                if (kind == K_HEX) begin
                    m_a = ((m_a << 4) | v) & MASK; m_disp = m_a; m_ovf = 0;
                end else if (kind == K_OP) begin
                    m_op = v & 3; m_mode = M_OW;
                end
            end
            M_OW: begin
                if (kind == K_HEX) begin
                    m_b = v; m_disp = v; m_mode = M_B;
                end else if (kind == K_OP) m_op = v & 3;
            end
            M_B: begin
                if (kind == K_HEX) begin
                    m_b = ((m_b << 4) | v) & MASK; m_disp = m_b;
                end else begin
                    if (m_op == 1) begin
                        mul = 1; r = m_a * m_b; m_ovf = (r > MASK);
                    end else if (m_op == 2) begin
                        m_ovf = (m_a < m_b); r = m_a - m_b;
                    end else begin
                        r = m_a + m_b; m_ovf = (r > MASK);
                    end
                    m_a = r & MASK; m_disp = m_a;
                    m_mode = (kind == K_OP) ? M_OW : M_RES;
                    if (kind == K_OP) m_op = v & 3;
                end
            end
            default: begin
                if (kind == K_OP) begin
                    m_op = v & 3; m_mode = M_OW;
                end else if (kind == K_HEX) begin
                    m_a = v; m_b = 0; m_ovf = 0; m_disp = v; m_mode = M_A;
                end
            end
        endcase
    endtask

    task automatic clear_strobes();
        newhex_i = 0; newop_i = 0; eq_i = 0;
    endtask

    task automatic press(input int kind, input int unsigned v);
        bit mul;
        int unsigned prev_disp;
        prev_disp = m_disp;
        model(kind, v, mul);
        @(negedge clock_i);
        newhex_i = (kind == K_HEX); newop_i = (kind != K_HEX); eq_i = (kind == K_EQ);
        hexcode_i = v[3:0]; opcode_i = v[1:0];
        @(negedge clock_i);
        clear_strobes();
        if (mul) begin
            for (int i = 0; i < W; i++) begin
                check("mul_busy", busy_o, 1);
                check("mul_hold_display", display_o, prev_disp);
                if (i < W - 1) begin
                    newhex_i = 1'($urandom_range(0, 1)); newop_i = 1'($urandom_range(0, 1));
                    eq_i = newop_i & 1'($urandom_range(0, 1));
                    hexcode_i = 4'($urandom); opcode_i = 2'($urandom);
                end
                @(negedge clock_i);
                clear_strobes();
            end
        end
        check("busy", busy_o, 0);
        check("display", display_o, m_disp);
        check("overflow", overflow_o, m_ovf);
    endtask

    task automatic reset_dut();
        @(posedge clock_i);
        #2 reset_n_i = 0;
        #1;
        check("rst_display", display_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overflow", overflow_o, 0);
        @(negedge clock_i);
        reset_n_i = 1;
        model_reset();
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            if (c == "+") press(K_OP, 0);
            else if (c == "*") press(K_OP, 1);
            else if (c == "-") press(K_OP, 2);
            else if (c == "=") press(K_EQ, 0);
            else if (c >= "0" && c <= "9") press(K_HEX, c - "0");
            else press(K_HEX, c - "A" + 10);
        end
    endtask

    initial begin
        reset_n_i = 0; hexcode_i = 0; opcode_i = 0;
        clear_strobes();
        model_reset();
        repeat (2) @(negedge clock_i);
        reset_n_i = 1;
        check("init_display", display_o, 0);

        reset_dut(); keys("1234"); check("spec_digits4", display_o, 16'h1234);
        keys("5"); check("spec_digits5", display_o, 16'h2345); check("spec_digits_ovf", overflow_o, 0);
        reset_dut(); keys("FF+1="); check("spec_add", display_o, 16'h0100); check("spec_add_ovf", overflow_o, 0);
        reset_dut(); keys("FFFF+2="); check("spec_add_wrap", display_o, 16'h0001); check("spec_add_wrap_ovf", overflow_o, 1);
        reset_dut(); keys("10-3="); check("spec_sub", display_o, 16'h000D);
        reset_dut(); keys("3-10="); check("spec_sub_neg", display_o, 16'hFFF3); check("spec_sub_neg_ovf", overflow_o, 1);
        reset_dut(); keys("12*34="); check("spec_mul", display_o, 16'h03A8); check("spec_mul_ovf", overflow_o, 0);
        reset_dut(); keys("1000*100="); check("spec_mul_big", display_o, 16'h0000); check("spec_mul_big_ovf", overflow_o, 1);
        reset_dut(); keys("2+3*"); check("spec_chain1", display_o, 16'h0005);
        keys("4="); check("spec_chain2", display_o, 16'h0014);
        keys("7"); check("spec_newcalc_ovf", overflow_o, 0);

        reset_dut(); keys("12*34");
        @(negedge clock_i); newop_i = 1; eq_i = 1; opcode_i = 0;
        @(negedge clock_i); clear_strobes();
        repeat (7) @(negedge clock_i);
        check("abort_busy_before", busy_o, 1);
        #2 reset_n_i = 0;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_display", display_o, 0);
        check("abort_overflow", overflow_o, 0);
        @(negedge clock_i); reset_n_i = 1; model_reset();
        repeat (W + 2) @(negedge clock_i);
        check("abort_no_late_result", display_o, 0);
        keys("9"); check("abort_recover", display_o, 16'h0009);

        reset_dut();
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 60) press(K_HEX, $urandom_range(0, 15));
            else if (r < 88) press(K_OP, $urandom_range(0, 3));
            else press(K_EQ, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
